// File: rtl/rx_uart_pkg.sv
// rx_uart_pkg: shared types and helpers for the packet-layer UART receiver.
//   clogb2  - ceiling log2, minimum 1 (address width for a RAM of a given depth)
//   state_t - receiver FSM states
//   err_t   - error code reported with pckt_done
package rx_uart_pkg;

   typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, FLUSH} state_t;

   typedef logic [2:0] err_t;

   localparam err_t ERR_OK      = 3'd0;
   localparam err_t ERR_CHK     = 3'd1;
   localparam err_t ERR_TIMEOUT = 3'd2;
   localparam err_t ERR_LEN     = 3'd3;
   localparam err_t ERR_BYTE    = 3'd4;

   function automatic int unsigned clogb2(input int unsigned value);
      int unsigned r;
      r = 1;
      while ((32'd1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/rx_uart_timeout.sv
// rx_uart_timeout: inter-byte silence counter.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   clr        - clears the count (takes priority over en)
//   en         - count enable
//   expired    - 1-cycle strobe when the count reaches LIMIT-1 while enabled and not cleared
module rx_uart_timeout #(
   parameter int unsigned LIMIT = 200
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   // A byte arriving in the expiry cycle wins, so clr masks expired.
   assign expired = en && !clr && (cnt == CW'(LIMIT - 1));

   always_ff @(posedge clk) begin
      if (reset || clr || expired) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/rx_uart_logic.sv
// rx_uart_logic: packet-layer receiver. Parses CMD, LEN, DATA[N], CHK frames from a byte stream,
// writes DATA to a RAM port and verifies that CMD+LEN+DATA+CHK sums to 8'hFF.
// Optional feature: define RXUART_BYTE_ERR_EN to abort frames on rx_err (err code 4).
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   rx_data/valid/err  - byte stream from the UART byte receiver
//   wr_addr/data/en    - registered RAM write port, one write per DATA byte
//   cmd_rx, len_rx     - CMD and raw LEN of the current/last frame (LEN 0 means NUMBER)
//   busy               - high outside IDLE
//   pckt_done/err_code - frame-finished pulse with 0 ok, 1 checksum, 2 timeout, 3 length, 4 byte
module rx_uart_logic
   import rx_uart_pkg::*;
#(
   parameter int unsigned CLOCK        = 10_000_000,
   parameter int unsigned BAUD         = 1_000_000,
   parameter int unsigned NUMBER       = 256,
   parameter int unsigned TIMEOUT_BITS = 20,
   localparam int unsigned AW          = clogb2(NUMBER)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   input  logic          rx_err,
   output logic [AW-1:0] wr_addr,
   output logic [7:0]    wr_data,
   output logic          wr_en,
   output logic [7:0]    cmd_rx,
   output logic [AW-1:0] len_rx,
   output logic          busy,
   output logic          pckt_done,
   output logic [2:0]    err_code
);

   localparam int unsigned FACTOR = CLOCK / BAUD;
   localparam int unsigned LIMIT  = TIMEOUT_BITS * FACTOR;
   localparam int unsigned NW     = AW + 1;

   state_t        state;
   logic [7:0]    sum;
   logic [NW-1:0] idx;
   logic [NW-1:0] n;
   logic          expired;
   logic          byte_err;
   logic          too_long;
   logic [NW-1:0] idx_next;

`ifdef RXUART_BYTE_ERR_EN
   assign byte_err = rx_err;
`else
   logic unused_rx_err;
   assign unused_rx_err = rx_err;
   assign byte_err      = 1'b0;
`endif

   assign too_long = {1'b0, rx_data} > 9'(NUMBER);
   assign idx_next = idx + NW'(1);

   rx_uart_timeout #(
      .LIMIT (LIMIT)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clr     (rx_valid || (state == IDLE)),
      .en      (state != IDLE),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         sum       <= '0;
         idx       <= '0;
         n         <= '0;
         wr_addr   <= '0;
         wr_data   <= '0;
         wr_en     <= 1'b0;
         cmd_rx    <= '0;
         len_rx    <= '0;
         busy      <= 1'b0;
         pckt_done <= 1'b0;
         err_code  <= ERR_OK;
      end else begin
         wr_en     <= 1'b0;
         pckt_done <= 1'b0;
         if (rx_valid) begin
            unique case (state)
               IDLE: begin
                  if (!byte_err) begin
                     cmd_rx <= rx_data;
                     sum    <= rx_data;
                     state  <= LEN;
                     busy   <= 1'b1;
                  end
               end
               LEN: begin
                  if (byte_err || too_long) begin
                     pckt_done <= 1'b1;
                     err_code  <= byte_err ? ERR_BYTE : ERR_LEN;
                     state     <= FLUSH;
                  end else begin
                     len_rx <= rx_data[AW-1:0];
                     n      <= (rx_data == 8'd0) ? NW'(NUMBER) : NW'(rx_data);
                     sum    <= sum + rx_data;
                     idx    <= '0;
                     state  <= DATA;
                  end
               end
               DATA: begin
                  if (byte_err) begin
                     pckt_done <= 1'b1;
                     err_code  <= ERR_BYTE;
                     state     <= FLUSH;
                  end else begin
                     wr_en   <= 1'b1;
                     wr_addr <= idx[AW-1:0];
                     wr_data <= rx_data;
                     sum     <= sum + rx_data;
                     idx     <= idx_next;
                     if (idx_next == n) state <= CHK;
                  end
               end
               CHK: begin
                  pckt_done <= 1'b1;
                  if (byte_err) begin
                     err_code <= ERR_BYTE;
                     state    <= FLUSH;
                  end else begin
                     err_code <= (rx_data == ~sum) ? ERR_OK : ERR_CHK;
                     state    <= IDLE;
                     busy     <= 1'b0;
                  end
               end
               FLUSH: ;
               default: state <= IDLE;
            endcase
         end else if (expired) begin
            // FLUSH ends silently; a frame in progress is reported as timed out.
            if (state != FLUSH) begin
               pckt_done <= 1'b1;
               err_code  <= ERR_TIMEOUT;
            end
            state <= IDLE;
            busy  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rx_uart_logic.sv
// tb_rx_uart_logic: scoreboard bench for rx_uart_logic. Two instances: NUMBER=256 (u_dut_a) and
// NUMBER=16 (u_dut_b), each with its own byte stream. Expected writes and frame reports are queued
// when stimulus is issued; per-instance monitors pop and compare on wr_en / pckt_done.
module tb_rx_uart_logic;

   localparam int GAP = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rxd_a, rxd_b;
   logic       rxv_a, rxv_b, rxe_a, rxe_b;

   logic [7:0] wr_addr_a, wr_data_a, wr_data_b, cmd_a, cmd_b, len_a;
   logic [3:0] wr_addr_b, len_b;
   logic       wr_en_a, wr_en_b, busy_a, busy_b, done_a, done_b;
   logic [2:0] err_a, err_b;

   int n_pass   = 0;
   int n_checks = 0;

   logic [15:0] wq_a[$], wq_b[$];
   logic [18:0] dq_a[$], dq_b[$];
   logic [15:0] we_a, we_b;
   logic [18:0] de_a, de_b;

   always #5 clk = ~clk;

   rx_uart_logic #(.NUMBER(256)) u_dut_a (
      .clk(clk), .reset(reset), .rx_data(rxd_a), .rx_valid(rxv_a), .rx_err(rxe_a),
      .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_en(wr_en_a), .cmd_rx(cmd_a), .len_rx(len_a),
      .busy(busy_a), .pckt_done(done_a), .err_code(err_a)
   );

   rx_uart_logic #(.NUMBER(16)) u_dut_b (
      .clk(clk), .reset(reset), .rx_data(rxd_b), .rx_valid(rxv_b), .rx_err(rxe_b),
      .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_en(wr_en_b), .cmd_rx(cmd_b), .len_rx(len_b),
      .busy(busy_b), .pckt_done(done_b), .err_code(err_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Monitors: every write / frame report must match the head of its queue.
   always @(negedge clk) begin
      if (wr_en_a) begin
         check("a_wr_expected", 32'(wq_a.size() != 0), 32'd1);
         if (wq_a.size() != 0) begin
            we_a = wq_a.pop_front();
            check("a_wr", {16'd0, wr_addr_a, wr_data_a}, {16'd0, we_a});
         end
      end
      if (done_a) begin
         check("a_done_expected", 32'(dq_a.size() != 0), 32'd1);
         if (dq_a.size() != 0) begin
            de_a = dq_a.pop_front();
            check("a_done", {13'd0, err_a, cmd_a, len_a}, {13'd0, de_a});
         end
      end
      if (wr_en_a && done_a) check("a_wr_done_excl", 32'd1, 32'd0);
   end

   always @(negedge clk) begin
      if (wr_en_b) begin
         check("b_wr_expected", 32'(wq_b.size() != 0), 32'd1);
         if (wq_b.size() != 0) begin
            we_b = wq_b.pop_front();
            check("b_wr", {16'd0, 4'd0, wr_addr_b, wr_data_b}, {16'd0, we_b});
         end
      end
      if (done_b) begin
         check("b_done_expected", 32'(dq_b.size() != 0), 32'd1);
         if (dq_b.size() != 0) begin
            de_b = dq_b.pop_front();
            check("b_done", {13'd0, err_b, cmd_b, 4'd0, len_b}, {13'd0, de_b});
         end
      end
   end

   task automatic send(input bit to_b, input logic [7:0] b, input logic e);
      @(posedge clk);
      #1;
      if (to_b) begin rxd_b = b; rxe_b = e; rxv_b = 1'b1; end
      else      begin rxd_a = b; rxe_a = e; rxv_a = 1'b1; end
      @(posedge clk);
      #1;
      rxv_a = 1'b0; rxv_b = 1'b0; rxe_a = 1'b0; rxe_b = 1'b0;
      repeat (GAP) @(posedge clk);
   endtask

   task automatic exp_wr(input bit to_b, input logic [7:0] a, input logic [7:0] d);
      if (to_b) wq_b.push_back({a, d});
      else      wq_a.push_back({a, d});
   endtask

   task automatic exp_done(input bit to_b, input logic [2:0] e, input logic [7:0] c,
                           input logic [7:0] l);
      if (to_b) dq_b.push_back({e, c, l});
      else      dq_a.push_back({e, c, l});
   endtask

   // CMD 5A, LEN 03, DATA 11 22 33: sum C3, good CHK is 3C.
   task automatic frame1(input bit to_b, input logic [7:0] chk, input logic [2:0] e);
      exp_wr(to_b, 8'h00, 8'h11);
      exp_wr(to_b, 8'h01, 8'h22);
      exp_wr(to_b, 8'h02, 8'h33);
      exp_done(to_b, e, 8'h5A, 8'h03);
      send(to_b, 8'h5A, 1'b0);
      send(to_b, 8'h03, 1'b0);
      send(to_b, 8'h11, 1'b0);
      send(to_b, 8'h22, 1'b0);
      send(to_b, 8'h33, 1'b0);
      send(to_b, chk, 1'b0);
   endtask

   task automatic drain(input string name, input int budget);
      int k;
      k = 0;
      while ((wq_a.size() + wq_b.size() + dq_a.size() + dq_b.size()) != 0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      @(negedge clk);
      check(name, 32'(wq_a.size() + wq_b.size() + dq_a.size() + dq_b.size()), 32'd0);
   endtask

   task automatic check_idle_a(input string name);
      @(negedge clk);
      check(name, {wr_addr_a, wr_data_a, cmd_a, len_a}, 32'd0);
      check({name, "_ctl"}, {26'd0, wr_en_a, busy_a, done_a, err_a}, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      rxd_a = '0; rxd_b = '0; rxv_a = 1'b0; rxv_b = 1'b0; rxe_a = 1'b0; rxe_b = 1'b0;
      repeat (3) @(posedge clk);
      check_idle_a("reset_a");
      check("reset_b", {18'd0, busy_b, done_b, wr_en_b, err_b, cmd_b, len_b}, 32'd0);
      #1 reset = 1'b0;

      // 1: good frame
      frame1(1'b0, 8'h3C, 3'd0);
      drain("drain1", 20);
      check("cmd_rx1", {24'd0, cmd_a}, 32'h5A);
      check("len_rx1", {24'd0, len_a}, 32'h03);
      check("busy_after1", {31'd0, busy_a}, 32'd0);

      // 2: bad checksum
      frame1(1'b0, 8'h3D, 3'd1);
      drain("drain2", 20);
      check("busy_after2", {31'd0, busy_a}, 32'd0);

      // 3: LEN 00 means 256 bytes; sum 01+00+(00..FF) = 81, CHK 7E
      for (int i = 0; i < 256; i++) exp_wr(1'b0, 8'(i), 8'(i));
      exp_done(1'b0, 3'd0, 8'h01, 8'h00);
      send(1'b0, 8'h01, 1'b0);
      send(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 256; i++) send(1'b0, 8'(i), 1'b0);
      send(1'b0, 8'h7E, 1'b0);
      drain("drain3", 20);

      // 4: timeout after 2 of 4 data bytes, then a normal frame
      exp_wr(1'b0, 8'h00, 8'h01);
      exp_wr(1'b0, 8'h01, 8'h02);
      exp_done(1'b0, 3'd2, 8'hAA, 8'h04);
      send(1'b0, 8'hAA, 1'b0);
      send(1'b0, 8'h04, 1'b0);
      send(1'b0, 8'h01, 1'b0);
      send(1'b0, 8'h02, 1'b0);
      check("busy_before_to", {31'd0, busy_a}, 32'd1);
      drain("drain4_to", 300);
      check("busy_after_to", {31'd0, busy_a}, 32'd0);
      frame1(1'b0, 8'h3C, 3'd0);
      drain("drain4", 20);

      // 5: NUMBER=16, LEN 14h too long; len_rx keeps its reset value
      exp_done(1'b1, 3'd3, 8'hC3, 8'h00);
      send(1'b1, 8'hC3, 1'b0);
      send(1'b1, 8'h14, 1'b0);
      drain("drain5_len", 20);
      for (int i = 0; i < 5; i++) send(1'b1, 8'(8'h40 + i), 1'b0);
      @(negedge clk);
      check("busy_flush", {31'd0, busy_b}, 32'd1);
      repeat (250) @(posedge clk);
      @(negedge clk);
      check("busy_after_flush", {31'd0, busy_b}, 32'd0);
      frame1(1'b1, 8'h3C, 3'd0);
      drain("drain5", 20);

      // 6: reset after the first data byte discards the frame
      exp_wr(1'b0, 8'h00, 8'h11);
      send(1'b0, 8'h5A, 1'b0);
      send(1'b0, 8'h03, 1'b0);
      send(1'b0, 8'h11, 1'b0);
      drain("drain6_pre", 20);
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      check_idle_a("reset_mid");
      #1 reset = 1'b0;
      repeat (300) @(posedge clk);
      frame1(1'b0, 8'h3C, 3'd0);
      drain("drain6", 20);

`ifdef RXUART_BYTE_ERR_EN
      exp_wr(1'b0, 8'h00, 8'h11);
      exp_done(1'b0, 3'd4, 8'h5A, 8'h03);
      send(1'b0, 8'h5A, 1'b0);
      send(1'b0, 8'h03, 1'b0);
      send(1'b0, 8'h11, 1'b0);
      send(1'b0, 8'h22, 1'b1);
      drain("drain_byte_err", 20);
      repeat (250) @(posedge clk);
      @(negedge clk);
      check("busy_after_byte_err", {31'd0, busy_a}, 32'd0);
`endif

      repeat (5) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
